// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the accumulator CPU (widths, opcodes, ALU ops).
package cpu_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 8;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd3;
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x DATA_W array, synchronous write, combinational read.
module stack_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with edge-detected push/pop strobes and sticky error flags.
module return_stack
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack_write,
  input  logic              stack_read,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] stack_out,
  output logic              out_en,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic [PTR_W-1:0]  sp
);
  localparam int AW = $clog2(DEPTH);
  logic wr_d, rd_d, push_ev, pop_ev, inc, dec, we, ov_set, un_set;
  logic [AW-1:0] sp_idx, top_idx, waddr;
  logic [DATA_W-1:0] rdata;
  assign push_ev = stack_write & ~wr_d;
  assign pop_ev = stack_read & ~rd_d;
  assign full = sp == PTR_W'(DEPTH);
  assign empty = sp == '0;
  assign out_en = stack_read & rd_d;
  assign sp_idx = sp[AW-1:0];
  assign top_idx = sp_idx - AW'(1);
  // a combined push+pop on a non-empty stack swaps the top entry in place
  assign we = push_ev & (pop_ev | ~full);
  assign waddr = (pop_ev & ~empty) ? top_idx : sp_idx;
  assign inc = push_ev & (pop_ev ? empty : ~full);
  assign dec = pop_ev & ~push_ev & ~empty;
  assign ov_set = push_ev & ~pop_ev & full;
  assign un_set = pop_ev & empty;
  stack_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(bus_in), .raddr(top_idx), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      stack_out <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      wr_d <= 1'b0;
      rd_d <= 1'b0;
    end else begin
      wr_d <= stack_write;
      rd_d <= stack_read;
      sp <= inc ? sp + PTR_W'(1) : dec ? sp - PTR_W'(1) : sp;
      stack_out <= pop_ev ? (empty ? '0 : rdata) : stack_out;
      overflow <= ov_set | (overflow & ~err_clr);
      underflow <= un_set | (underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed checks of push/pop, limits, error flags and reset for return_stack.
module tb_return_stack;
  logic clk = 1'b0, rst = 1'b1, stack_write = 1'b0, stack_read = 1'b0, err_clr = 1'b0;
  logic [7:0] bus_in = '0, stack_out;
  logic out_en, full, empty, overflow, underflow;
  logic [3:0] sp;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  return_stack dut (
    .clk(clk), .rst(rst), .stack_write(stack_write), .stack_read(stack_read), .bus_in(bus_in),
    .err_clr(err_clr), .stack_out(stack_out), .out_en(out_en), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .sp(sp)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] v);
    bus_in = v;
    stack_write = 1'b1;
    tick();
    stack_write = 1'b0;
    tick();
  endtask
  task automatic pop(input string tag, input logic [7:0] exp);
    stack_read = 1'b1;
    #1 chk({tag, "_oe1"}, out_en, 0);
    tick();
    chk({tag, "_val"}, stack_out, exp);
    chk({tag, "_oe2"}, out_en, 1);
    tick();
    stack_read = 1'b0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sp", sp, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out", stack_out, 0);
    chk("rst_oe", out_en, 0);
    chk("rst_ov", overflow, 0);
    chk("rst_un", underflow, 0);
    push(8'h12);
    push(8'h34);
    push(8'h56);
    chk("p3_sp", sp, 3);
    chk("p3_empty", empty, 0);
    pop("pop56", 8'h56);
    chk("pop56_sp", sp, 2);
    bus_in = 8'h99;
    stack_write = 1'b1;
    stack_read = 1'b1;
    tick();
    chk("swap_out", stack_out, 8'h34);
    chk("swap_sp", sp, 2);
    stack_write = 1'b0;
    stack_read = 1'b0;
    tick();
    pop("pop99", 8'h99);
    chk("pop99_sp", sp, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("fill_full", full, 1);
    chk("fill_sp", sp, 8);
    push(8'hFF);
    chk("ovf_flag", overflow, 1);
    chk("ovf_sp", sp, 8);
    for (int i = 7; i >= 0; i--) pop("drain", 8'h10 + 8'(i));
    chk("drain_empty", empty, 1);
    chk("drain_ovf_sticky", overflow, 1);
    pop("pop_empty", 8'h00);
    chk("unf_flag", underflow, 1);
    chk("unf_sp", sp, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_un", underflow, 0);
    chk("clr_ov", overflow, 0);
    err_clr = 1'b1;
    stack_read = 1'b1;
    tick();
    err_clr = 1'b0;
    stack_read = 1'b0;
    chk("set_wins", underflow, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_un2", underflow, 0);
    bus_in = 8'h2A;
    stack_write = 1'b1;
    repeat (5) tick();
    stack_write = 1'b0;
    tick();
    chk("hold_sp", sp, 1);
    stack_read = 1'b1;
    tick();
    chk("ret1_out", stack_out, 8'h2A);
    chk("ret1_oe", out_en, 1);
    rst = 1'b1;
    tick();
    chk("midrst_sp", sp, 0);
    chk("midrst_oe", out_en, 0);
    chk("midrst_out", stack_out, 0);
    rst = 1'b0;
    tick();
    chk("post_un", underflow, 1);
    chk("post_sp", sp, 0);
    chk("post_out", stack_out, 0);
    stack_read = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack for the accumulator CPU.
- Consumes the control block's stack_write/stack_read strobes and the shared datapath bus.
- CALL pushes the PC value that is on the bus; RETURN pops the saved PC back onto the bus for the PC load.
- LIFO register file with depth tracking, full/empty status and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, width of bus words and stored return addresses.
- DEPTH, 8, number of stack entries; must be a power of two, 2 or more.
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer / occupancy count (0..DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stack_write  input  1  push strobe from the control block; level-sensitive, acted on at its rising edge.
- stack_read  input  1  pop strobe from the control block; held high 2 cycles on RETURN; acted on at its rising edge.
- bus_in  input  DATA_W  datapath bus value (PC during CALL).
- err_clr  input  1  clears the sticky error flags.
- stack_out  output  DATA_W  popped value (registered).
- out_en  output  1  bus drive enable for stack_out.
- full  output  1  sp == DEPTH.
- empty  output  1  sp == 0.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- sp  output  PTR_W  current occupancy.

Behaviour:
- Reset: sp=0, stack_out=0, out_en=0, overflow=0, underflow=0, wr_d=0, rd_d=0. Storage array is not cleared.
- Edge detect uses wr_d/rd_d, which are registered copies of the strobes:
  - push_ev = stack_write & ~wr_d.
  - pop_ev = stack_read & ~rd_d.
  - A strobe already high in the first cycle after reset counts as an edge.
- Push only (push_ev & ~pop_ev):
  - Not full: mem[sp] <= bus_in and sp <= sp+1.
  - Full: storage and sp unchanged; overflow <= 1.
- Pop only (pop_ev & ~push_ev):
  - Not empty: stack_out <= mem[sp-1] and sp <= sp-1.
  - Empty: stack_out <= 0, sp stays 0, underflow <= 1.
- Simultaneous push_ev & pop_ev:
  - Not empty: stack_out <= mem[sp-1], mem[sp-1] <= bus_in, sp unchanged.
  - Empty: stack_out <= 0, underflow <= 1, then the push proceeds (mem[0] <= bus_in, sp <= 1).
- Pop latency: stack_out is valid in the cycle after the stack_read rising edge and holds until the next pop event or reset.
- out_en = stack_read & rd_d (combinational from registered rd_d). It is high in the second cycle of the two-cycle RETURN strobe, which is the cycle the control block asserts pc_write. It is never high in the first strobe cycle.
- A held strobe (more than 1 cycle) produces exactly one event. A new event needs the strobe to deassert for at least 1 cycle.
- full and empty are combinational from sp.
- err_clr clears both sticky flags. If an error event occurs in the same cycle as err_clr, the set wins.
- rst mid-operation (for example between the two stack_read cycles): state returns to reset values and out_en drops the next cycle. rd_d=0 after reset, so a still-high stack_read counts as a new pop edge.

Decomposition:
- Package cpu_pkg holds:
  - Default DATA_W and DEPTH constants.
  - Opcode constants OP_ADD=3'd0, OP_LOAD=3'd1, OP_STORE=3'd2, OP_CALL=3'd3, OP_RET=3'd4.
  - ALU op constants ALU_PASS=3'd3.
- One sub-module, stack_regfile: DEPTH x DATA_W synchronous-write, combinational-read array with we/waddr/wdata/raddr/rdata. Pointer, flags and edge detection stay in return_stack.

Test Plan:
- Reset, then push 0x12, 0x34, 0x56 (1-cycle stack_write each, gaps between) -> sp=3, empty=0. Two-cycle stack_read -> stack_out=0x56 with out_en=1 only in the 2nd cycle; sp=2.
- Push 8 values 0x10..0x17 -> full=1, sp=8. 9th push of 0xFF -> overflow=1, sp=8. Then 8 pops return 0x17 down to 0x10 in order.
- Pop from empty -> stack_out=0x00, underflow=1, sp=0. Assert err_clr -> underflow=0 next cycle.
- stack_write held high 5 cycles with bus_in=0x2A -> exactly one push, sp=1.
- With sp=2 and top=0x34, simultaneous push_ev (bus_in=0x99) and pop_ev -> stack_out=0x34, sp=2. Next pop returns 0x99.
- Assert rst between the two RETURN strobe cycles, then hold stack_read -> sp=0, out_en=0 in the reset cycle. The post-reset edge is treated as a pop from empty, so underflow=1.
